// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_ALU    = 2'b10,
    PC_JALR   = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    S_BOOT = 2'b00,
    S_RUN  = 2'b01,
    S_TRAP = 2'b10
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

  // Compressed (16-bit) alignment only needs bit 0 clear; 32-bit needs both low bits clear.
  function automatic logic is_misaligned(input logic [1:0] lsb, input int ialign);
    return (ialign == 32) ? (lsb != 2'b00) : lsb[0];
  endfunction

endpackage

// File: rtl/pc_history_buf.sv
// Circular buffer of previously retired PC values; reads are relative to the newest entry.
module pc_history_buf #(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   rd_idx,
  output logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // Write the old PC at the pointer and advance; reset clears every entry so unwritten slots read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wr_ptr] <= wdata;
      wr_ptr      <= wr_ptr + AW'(1);
    end
  end

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  assign rd_ptr  = wr_ptr - AW'(1) - rd_idx;
  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/pc_unit.sv
// Program-counter generator: boot/run/trap sequencing, next-PC selection,
// misaligned-target trapping with sticky capture.
// Optional PC history buffer enabled by defining PC_HISTORY_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
  parameter int              IALIGN       = 32,
  parameter int              HIST_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic [1:0]                    PCSrc,
  input  logic [XLEN-1:0]               PC_branch_offset,
  input  logic [XLEN-1:0]               ALU_result,
  input  logic                          trap_ack,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic [XLEN-1:0]               PC_reg,
  output logic [XLEN-1:0]               PC_Plus4,
  output logic                          PC_valid,
  output logic                          misalign_trap,
  output logic [XLEN-1:0]               bad_target,
  output logic [XLEN-1:0]               hist_data
);

  pc_state_e              state, state_n;
  logic [XLEN-1:0]        pc_n, bad_n, target;
  logic                   valid_n, trap_n, hist_we, misal;
  logic signed [XLEN-1:0] pc_s, off_s;

  assign PC_Plus4 = PC_reg + XLEN'(4);
  assign pc_s     = signed'(PC_reg);
  assign off_s    = signed'(PC_branch_offset);

  // Candidate target from the selected source; all sums wrap modulo 2^XLEN.
  always_comb begin
    target = PC_Plus4;
    unique case (pcsrc_e'(PCSrc))
      PC_PLUS4:  target = PC_Plus4;
      PC_BRANCH: target = unsigned'(pc_s + off_s);
      PC_ALU:    target = ALU_result;
      PC_JALR:   target = {ALU_result[XLEN-1:1], 1'b0};
    endcase
  end

  assign misal = is_misaligned(target[1:0], IALIGN);

  // Next-state and next-register values for the boot/run/trap sequencer.
  always_comb begin
    state_n = state;
    pc_n    = PC_reg;
    valid_n = PC_valid;
    trap_n  = misalign_trap;
    bad_n   = bad_target;
    hist_we = 1'b0;
    unique case (state)
      S_BOOT: begin
        state_n = S_RUN;
        valid_n = 1'b1;
      end
      S_RUN: begin
        if (!stall) begin
          if (misal) begin
            state_n = S_TRAP;
            pc_n    = TRAP_VECTOR;
            bad_n   = target;
            trap_n  = 1'b1;
            valid_n = 1'b0;
          end else begin
            pc_n    = target;
            hist_we = 1'b1;
          end
        end
      end
      S_TRAP: begin
        if (trap_ack) begin
          state_n = S_RUN;
          valid_n = 1'b1;
          trap_n  = 1'b0;
        end
      end
      default: begin
        state_n = S_BOOT;
        valid_n = 1'b0;
      end
    endcase
  end

  // State and architectural registers; reset returns everything to the boot condition at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_BOOT;
      PC_reg        <= RESET_VECTOR;
      PC_valid      <= 1'b0;
      misalign_trap <= 1'b0;
      bad_target    <= '0;
    end else begin
      state         <= state_n;
      PC_reg        <= pc_n;
      PC_valid      <= valid_n;
      misalign_trap <= trap_n;
      bad_target    <= bad_n;
    end
  end

`ifdef PC_HISTORY_EN
  pc_history_buf #(
    .XLEN  (XLEN),
    .DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk     (clk),
    .rst     (rst),
    .we      (hist_we),
    .wdata   (PC_reg),
    .rd_idx  (hist_idx),
    .rd_data (hist_data)
  );
`else
  logic unused_hist;
  assign unused_hist = ^{hist_idx, hist_we};
  assign hist_data   = '0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a driver applies stimulus on the falling edge and
// queues the expected post-edge outputs from a behavioural model; a monitor checks
// them just after each rising edge.
module tb_pc_unit;

  localparam int HD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] PC_branch_offset = '0;
  logic [31:0] ALU_result = '0;
  logic        trap_ack = 1'b0;
  logic [1:0]  hist_idx = '0;
  logic [31:0] PC_reg, PC_Plus4, bad_target, hist_data;
  logic        PC_valid, misalign_trap;

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .IALIGN(32), .HIST_DEPTH(HD)) dut (
    .clk(clk), .rst(rst), .stall(stall), .PCSrc(PCSrc),
    .PC_branch_offset(PC_branch_offset), .ALU_result(ALU_result),
    .trap_ack(trap_ack), .hist_idx(hist_idx),
    .PC_reg(PC_reg), .PC_Plus4(PC_Plus4), .PC_valid(PC_valid),
    .misalign_trap(misalign_trap), .bad_target(bad_target), .hist_data(hist_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        trap;
    logic [31:0] bad;
    logic [31:0] hist;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: plain variables describing the architectural behaviour.
  logic [31:0] m_pc, m_bad;
  logic        m_valid, m_trap, m_booted, m_trapped;
  logic [31:0] m_hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] exp_hist(input int idx);
`ifdef PC_HISTORY_EN
    return (idx < m_hist.size()) ? m_hist[idx] : 32'h0;
`else
    return 32'h0;
`endif
  endfunction

  task automatic push_exp();
    exp_t e;
    e.pc = m_pc; e.valid = m_valid; e.trap = m_trap; e.bad = m_bad;
    e.hist = exp_hist(int'(hist_idx));
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_bad = 32'h0; m_valid = 1'b0; m_trap = 1'b0;
    m_booted = 1'b0; m_trapped = 1'b0;
    m_hist.delete();
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    push_exp();
  endtask

  task automatic step(input logic st, input logic [1:0] src, input logic [31:0] off,
                      input logic [31:0] alu, input logic ack, input logic [1:0] idx);
    logic [31:0] tgt;
    @(negedge clk);
    rst = 1'b0; stall = st; PCSrc = src; PC_branch_offset = off;
    ALU_result = alu; trap_ack = ack; hist_idx = idx;
    if (!m_booted) begin
      m_booted = 1'b1;
      m_valid  = 1'b1;
    end else if (m_trapped) begin
      if (ack) begin
        m_trapped = 1'b0; m_valid = 1'b1; m_trap = 1'b0;
      end
    end else if (!st) begin
      case (src)
        2'd0:    tgt = m_pc + 32'd4;
        2'd1:    tgt = m_pc + off;
        2'd2:    tgt = alu;
        default: tgt = alu & 32'hFFFF_FFFE;
      endcase
      if (tgt % 4 != 0) begin
        m_trapped = 1'b1; m_pc = 32'h100; m_bad = tgt; m_trap = 1'b1; m_valid = 1'b0;
      end else begin
        m_hist.push_front(m_pc);
        if (m_hist.size() > HD) void'(m_hist.pop_back());
        m_pc = tgt;
      end
    end
    push_exp();
  endtask

  // Monitor: compare every queued expectation just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("PC_reg",        PC_reg,                 mon_e.pc);
      chk("PC_Plus4",      PC_Plus4,               mon_e.pc + 32'd4);
      chk("PC_valid",      {31'b0, PC_valid},      {31'b0, mon_e.valid});
      chk("misalign_trap", {31'b0, misalign_trap}, {31'b0, mon_e.trap});
      chk("bad_target",    bad_target,             mon_e.bad);
      chk("hist_data",     hist_data,              mon_e.hist);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    hold_reset();
    hold_reset();

    // Boot then sequential fetch 0, 4, 8.
    step(0, 2'd0, 0, 0, 0, 0);
    step(0, 2'd0, 0, 0, 0, 0);
    step(0, 2'd0, 0, 0, 0, 0);
    // Backward branch to 0, forward branch to 0x10.
    step(0, 2'd1, 32'hFFFF_FFF8, 0, 0, 0);
    step(0, 2'd1, 32'h0000_0010, 0, 0, 0);
    // JALR to 0x122 traps on bit 1.
    step(0, 2'd3, 0, 32'h0000_0123, 0, 0);
    for (int i = 0; i < 5; i++) step(i[0], 2'(i), 32'h4, 32'h40, 0, 0);
    step(0, 2'd0, 0, 0, 1, 0);
    // JALR to 0x200 after clearing bit 0: no trap.
    step(0, 2'd3, 0, 32'h0000_0201, 0, 0);
    // Stall holds despite a pending jump; release takes it.
    for (int i = 0; i < 4; i++) step(1, 2'd2, 0, 32'h40, 0, 0);
    step(0, 2'd2, 0, 32'h40, 0, 0);
    // trap_ack outside trap has no effect.
    step(0, 2'd0, 0, 0, 1, 0);

    // History: run PCs 0..0x14, then read every index while stalled.
    hold_reset();
    step(0, 2'd0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 2'd0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 2'd0, 0, 0, 0, 2'(i));

    // Asynchronous reset while trapped must act before the next edge.
    step(0, 2'd2, 0, 32'h0000_0006, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pc",    PC_reg,                 32'h0);
    chk("async_rst_trap",  {31'b0, misalign_trap}, 32'h0);
    chk("async_rst_valid", {31'b0, PC_valid},      32'h0);
    chk("async_rst_bad",   bad_target,             32'h0);
    model_reset();
    push_exp();

    // Randomised traffic against the model.
    step(0, 2'd0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 1) ? $urandom : (32'($urandom_range(0, 64)) - 32'd32),
           ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1023)),
           ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));
      if (i == 200) hold_reset();
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
